// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes, an accumulator and status flags.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   in_valid/ready   input handshake; in_a (A_WIDTH) is extended to WIDTH, in_b is operand B
//   in_op            operation code, in_use_acc selects the accumulator as B,
//                    in_acc_wr writes the result back into the accumulator
//   acc_clr          synchronous accumulator clear, independent of the handshake
//   out_valid/ready  output handshake; out_result plus zero/carry/ovf/neg flags
//   acc_value        registered accumulator contents
module alu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned A_WIDTH  = 8,
  parameter bit          A_SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  input  logic               in_use_acc,
  input  logic               in_acc_wr,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_neg,
  output logic [WIDTH-1:0]   acc_value
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpNot  = 3'b100;
  localparam logic [2:0] OpZero = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;
  localparam logic [2:0] OpSlt  = 3'b111;

  // Stage 1: captured operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic             s1_use_acc_q, s1_acc_wr_q;

  // Stage 2: registered result and flags
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_zero_q, s2_carry_q, s2_ovf_q, s2_neg_q;

  logic [WIDTH-1:0] acc_q;

  logic s2_move, s1_adv, accept;

  assign s2_move  = s2_valid_q && out_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  // Operand A extension
  logic [WIDTH-1:0] a_ext;
  always_comb begin
    a_ext = WIDTH'(in_a);
    if (A_SIGNED) begin
      for (int unsigned i = A_WIDTH; i < WIDTH; i++) begin
        a_ext[i] = in_a[A_WIDTH-1];
      end
    end
  end

  // Stage 2 compute; B resolves against the accumulator of the advance cycle
  logic [WIDTH-1:0] b_op, res;
  logic [WIDTH:0]   sum, diff;
  logic             carry, ovf;

  always_comb begin
    b_op  = s1_use_acc_q ? acc_q : s1_b_q;
    sum   = {1'b0, s1_a_q} + {1'b0, b_op};
    diff  = {1'b0, s1_a_q} - {1'b0, b_op};
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (s1_op_q)
      OpAdd: begin
        res   = sum[Msb:0];
        carry = sum[WIDTH];
        ovf   = (s1_a_q[Msb] == b_op[Msb]) && (sum[Msb] != s1_a_q[Msb]);
      end
      OpSub: begin
        res   = diff[Msb:0];
        carry = diff[WIDTH];  // borrow: A < B unsigned
        ovf   = (s1_a_q[Msb] != b_op[Msb]) && (diff[Msb] != s1_a_q[Msb]);
      end
      OpAnd:  res = s1_a_q & b_op;
      OpOr:   res = s1_a_q | b_op;
      OpNot:  res = ~b_op;
      OpZero: res = '0;
      OpXor:  res = s1_a_q ^ b_op;
      OpSlt:  res = WIDTH'($signed(s1_a_q) < $signed(b_op));
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s1_use_acc_q <= 1'b0;
      s1_acc_wr_q  <= 1'b0;
    end else if (accept) begin
      s1_valid_q   <= 1'b1;
      s1_a_q       <= a_ext;
      s1_b_q       <= in_b;
      s1_op_q      <= in_op;
      s1_use_acc_q <= in_use_acc;
      s1_acc_wr_q  <= in_acc_wr;
    end else if (s1_adv) begin
      s1_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_carry_q  <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_neg_q    <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q  <= 1'b1;
      s2_result_q <= res;
      s2_zero_q   <= (res == '0);
      s2_carry_q  <= carry;
      s2_ovf_q    <= ovf;
      s2_neg_q    <= res[Msb];
    end else if (s2_move) begin
      s2_valid_q  <= 1'b0;
    end
  end

  // Clear wins over a simultaneous write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (s1_adv && s1_acc_wr_q) begin
      acc_q <= res;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_carry  = s2_carry_q;
  assign out_ovf    = s2_ovf_q;
  assign out_neg    = s2_neg_q;
  assign acc_value  = acc_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshakes, a result accumulator and status flags. It replaces the purely combinational ALU in the lab datapath: a narrow operand A is extended to the datapath width, and operand B comes either from the port or from the internal accumulator. Results and flags are registered, and the block sustains one operation per cycle under backpressure.

## Interface
- `WIDTH`, 32: datapath, result and accumulator width.
- `A_WIDTH`, 8: width of `in_a`. Must satisfy 1 ≤ A_WIDTH ≤ WIDTH.
- `A_SIGNED`, 0: 0 = zero-extend `in_a` to WIDTH; 1 = sign-extend.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an input transaction is present.
- `in_ready`  out  1  the block accepts the transaction this cycle.
- `in_a`  in  A_WIDTH  operand A, before extension.
- `in_b`  in  WIDTH  operand B; ignored when `in_use_acc` = 1.
- `in_op`  in  3  operation code (see Operation).
- `in_use_acc`  in  1  use the accumulator as operand B.
- `in_acc_wr`  in  1  write this transaction's result into the accumulator.
- `acc_clr`  in  1  synchronous accumulator clear; independent of the handshake.
- `out_valid`  out  1  a result is present.
- `out_ready`  in  1  the consumer takes the result this cycle.
- `out_result`  out  WIDTH  result.
- `out_zero`, `out_carry`, `out_ovf`, `out_neg`  out  1 each  flags belonging to `out_result`.
- `acc_value`  out  WIDTH  current accumulator contents.

## Operation
- A = extend(`in_a`) per A_SIGNED. B = `in_use_acc` ? accumulator : `in_b`.
- Operation codes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 NOT: ~B.
  - 101 ZERO: 0.
  - 110 XOR: A^B.
  - 111 SLT: signed A<B gives 1, otherwise 0.
- All arithmetic is modulo 2^WIDTH.
- Flags:
  - `zero`: result == 0.
  - `neg`: result[WIDTH−1].
  - `carry`: carry-out for ADD; borrow (A<B unsigned) for SUB; 0 for all other ops.
  - `ovf`: signed overflow for ADD/SUB; 0 for all other ops.
- Stage 1 (S1) registers A, B-source select, `in_b`, op, `in_use_acc` and `in_acc_wr` on accept (`in_valid` && `in_ready`).
- Stage 2 (S2) computes the result when S1 advances into S2. At that point B resolves to the accumulator value current in that cycle. Result and flags are registered into S2.
- Accumulator update on the same edge as an S1→S2 advance with `acc_wr` = 1. Consequently, back-to-back dependent accumulates chain with no stall and no hazard.
- `acc_clr`: the accumulator becomes 0 on the next edge.
  - `acc_clr` has priority over a simultaneous accumulator write.
  - A transaction computing in the same cycle still reads the pre-clear value.
- Ordering: results emerge in accept order. No transaction is dropped or duplicated.

## Timing
- Reset (async assert, clocked-domain release):
  - S1/S2 valid = 0, so `out_valid` = 0 and `in_ready` = 1.
  - `out_result` = 0, all flags = 0, accumulator and `acc_value` = 0.
  - In-flight transactions are discarded.
- S2 move = S2 valid && `out_ready`.
- S1 advance = S1 valid && (!S2 valid || `out_ready`).
- `in_ready` = !S1 valid || S1 advance. This is a combinational path from `out_ready`, which is permitted.
- Latency: accept at edge k gives `out_valid` high after edge k+1 (result registered at k+1), when no backpressure.
- Throughput: 1 transaction per cycle while `out_ready` = 1.
- Backpressure:
  - S2 holds `out_result` and flags stable while `out_valid` && !`out_ready`.
  - At most 2 transactions are held; `in_ready` is low when both stages are full and `out_ready` = 0.
- `out_valid` never drops without a handshake, except on reset.
- `acc_value` is the registered accumulator and reflects writes one edge after the S1→S2 advance.

## Test plan
- ADD, defaults, `in_a`=8'hFF, `in_b`=1 -> `out_result`=0x00000100, zero/carry/ovf/neg = 0, `out_valid` one cycle after accept. ZERO op -> 0, zero=1. NOT with `in_b`=0 -> 0xFFFFFFFF, neg=1.
- SUB with a=3, b=5 -> 0xFFFFFFFE, carry=1, neg=1, ovf=0. ADD with a=1, b=0x7FFFFFFF -> 0x80000000, ovf=1, neg=1, carry=0. SLT with A_SIGNED=1, a=8'hFF, b=0 -> 1.
- `acc_clr`, then three back-to-back ADDs with use_acc=1, acc_wr=1 and a=1,2,3 -> results 1, 3, 6 on consecutive cycles, `acc_value`=6, no stall.
- `acc_clr` in the same cycle as an ADD acc_wr advance with acc=6 and a=1 -> result 7, accumulator 0 afterward.
- `out_ready`=0 for 4 cycles while sending 3 transactions -> `in_ready` drops after 2 are accepted, S2 output stays stable; after release, 3 results arrive in order with no loss or duplication.
- Assert `reset` with 2 transactions in flight -> `out_valid`=0, `acc_value`=0 and outputs 0 immediately. After release, the first new transaction completes normally.
